// File: rtl/fan_duty_sequencer.sv
// Closed-loop fan/heater duty sequencer: per-PWM-period temperature step control with
// hysteresis, latched over-temperature alarm and DC-register handshake. Option: FAN_KICK_EN.
module fan_duty_sequencer #(
  parameter int unsigned PERIOD_CYC  = 50001,
  parameter int unsigned ADC_SHIFT   = 8,
  parameter int unsigned HYST        = 2,
  parameter logic [15:0] STEP        = 16'd2500,
  parameter logic [15:0] DC_MIN      = 16'd10000,
  parameter logic [15:0] DC_MAX      = 16'd50000,
  parameter int unsigned ALARM_DELTA = 10,
  parameter int unsigned ALARM_CNT   = 4,
  parameter int unsigned KICK_TICKS  = 2
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst_n,
  input  logic        i_en,
  input  logic [15:0] adc_reg,
  input  logic [7:0]  temp_set_reg,
  input  logic        i_dc_ack,
  output logic [15:0] o_dc,
  output logic        o_dc_wr,
  output logic        o_alarm,
  output logic        o_buzzer,
  output logic [2:0]  o_state
);

  localparam int PER_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam int CNT_W = $clog2(ALARM_CNT + 1);
  localparam logic signed [9:0] HYST_S  = 10'(HYST);
  localparam logic signed [9:0] DELTA_S = 10'(ALARM_DELTA);

  typedef enum logic [2:0] {
    S_OFF = 3'd0, S_WAIT = 3'd1, S_SAMPLE = 3'd2, S_CALC = 3'd3, S_WRITE = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [PER_W-1:0]  per_cnt;
  logic [7:0]        temp_q;
  logic [CNT_W-1:0]  alarm_cnt, cnt_next;
  logic              shutdown;
  logic              alarm_next;
  logic              tick, shut;
  logic [15:0]       dc_rule, dc_calc;
  logic [16:0]       sum_up, dn_limit;
  logic signed [9:0] temp_s, set_s, hi_s, lo_s, al_s;
  logic              unused_bits;

  assign unused_bits = ^{adc_reg[15:ADC_SHIFT+8], adc_reg[ADC_SHIFT-1:0]};

  assign tick = (state != S_OFF) && (per_cnt == PER_W'(PERIOD_CYC - 1));
  assign shut = !i_en && (state == S_WAIT || state == S_SAMPLE || state == S_CALC);

  // Signed 10-bit compares so that set-HYST can go below zero.
  assign temp_s   = $signed({2'b00, temp_q});
  assign set_s    = $signed({2'b00, temp_set_reg});
  assign hi_s     = set_s + HYST_S;
  assign lo_s     = set_s - HYST_S;
  assign al_s     = set_s + DELTA_S;
  assign sum_up   = {1'b0, o_dc} + {1'b0, STEP};
  assign dn_limit = {1'b0, DC_MIN} + {1'b0, STEP};

  always_comb begin
    alarm_next = o_alarm;
    cnt_next   = '0;
    if (o_alarm && temp_s < set_s) begin
      alarm_next = 1'b0;
    end else if (temp_s >= al_s) begin
      cnt_next   = (alarm_cnt == CNT_W'(ALARM_CNT)) ? alarm_cnt : alarm_cnt + CNT_W'(1);
      alarm_next = o_alarm || (cnt_next == CNT_W'(ALARM_CNT));
    end
  end

  always_comb begin
    dc_rule = o_dc;
    if (temp_s > hi_s) begin
      if (o_dc == 16'd0)                 dc_rule = DC_MIN;
      else if (sum_up > {1'b0, DC_MAX})  dc_rule = DC_MAX;
      else                               dc_rule = sum_up[15:0];
    end else if (temp_s < lo_s) begin
      if (o_dc == DC_MIN || o_dc == 16'd0) dc_rule = 16'd0;
      else if ({1'b0, o_dc} <= dn_limit)   dc_rule = DC_MIN;
      else                                 dc_rule = o_dc - STEP;
    end
  end

`ifdef FAN_KICK_EN
  localparam int KICK_W = $clog2(KICK_TICKS + 2);
  logic [KICK_W-1:0] kick_q, kick_next;

  // Counter is loaded one above the hold length; its last step issues the DC_MIN write.
  always_comb begin
    kick_next = kick_q;
    dc_calc   = dc_rule;
    if (alarm_next) begin
      kick_next = '0;
      dc_calc   = DC_MAX;
    end else if (kick_q > KICK_W'(1)) begin
      kick_next = kick_q - KICK_W'(1);
      dc_calc   = DC_MAX;
    end else if (kick_q == KICK_W'(1)) begin
      kick_next = '0;
      dc_calc   = DC_MIN;
    end else if (o_dc == 16'd0 && dc_rule != 16'd0) begin
      kick_next = KICK_W'(KICK_TICKS + 1);
      dc_calc   = DC_MAX;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n)            kick_q <= '0;
    else if (shut)              kick_q <= '0;
    else if (state == S_CALC)   kick_q <= kick_next;
  end
`else
  localparam int unused_kick = KICK_TICKS;
  assign dc_calc = alarm_next ? DC_MAX : dc_rule;
`endif

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) state <= S_OFF;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_OFF:    if (i_en) state_next = S_WAIT;
      S_WAIT:   if (!i_en) state_next = (o_dc != 16'd0) ? S_WRITE : S_OFF;
                else if (tick) state_next = S_SAMPLE;
      S_SAMPLE: if (!i_en) state_next = (o_dc != 16'd0) ? S_WRITE : S_OFF;
                else state_next = S_CALC;
      S_CALC:   if (!i_en) state_next = (o_dc != 16'd0) ? S_WRITE : S_OFF;
                else state_next = (dc_calc != o_dc) ? S_WRITE : S_WAIT;
      S_WRITE:  if (i_dc_ack) state_next = shutdown ? S_OFF : S_WAIT;
      default:  state_next = S_OFF;
    endcase
  end

  always_comb begin
    o_dc_wr  = (state == S_WRITE);
    o_state  = state;
    o_buzzer = o_alarm;
  end

  // o_dc only changes when entering WRITE, so it is stable for the whole handshake.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      per_cnt   <= '0;
      temp_q    <= '0;
      alarm_cnt <= '0;
      o_alarm   <= 1'b0;
      o_dc      <= '0;
      shutdown  <= 1'b0;
    end else begin
      per_cnt <= (state == S_OFF || tick) ? '0 : per_cnt + PER_W'(1);
      if (shut) begin
        o_alarm   <= 1'b0;
        alarm_cnt <= '0;
        if (o_dc != 16'd0) begin
          o_dc     <= '0;
          shutdown <= 1'b1;
        end
      end else if (state == S_SAMPLE) begin
        temp_q <= adc_reg[ADC_SHIFT +: 8];
      end else if (state == S_CALC) begin
        o_alarm   <= alarm_next;
        alarm_cnt <= cnt_next;
        if (dc_calc != o_dc) begin
          o_dc     <= dc_calc;
          shutdown <= 1'b0;
        end
      end
    end
  end

endmodule
